scalar_mult_ctrl: RTL and testbench
===================================

// Module: scalar_mult_ctrl
// PURPOSE
//  Sequences an external point_add unit (extended coords, curve448) to compute Q = k*P by
//  MSB-first double-and-add. Owns the point_add request/result handshake and the running
//  accumulator; sits between the X448 top-level command path and point_add.
//  The final result is always normalised to affine (Z=1) by one closing point_add pass.
// PARAMETERS
//  NBITS  448  scalar width; bits processed NBITS-1 down to 0
//  W      448  field element width
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      async active-low reset
//  scalar       in   NBITS  k, sampled at request accept
//  px,py,pt,pz  in   W each base point P (extended), sampled at request accept
//  req_valid    in   1      start request
//  req_ready    out  1      one-cycle accept pulse
//  req_busy     out  1      high from accept until res_valid rises
//  qx,qy,qt,qz  out  W each result k*P, affine (qz=1)
//  res_valid    out  1      result valid, held until res_ready
//  res_ready    in   1      result consumed
//  pa_x1..pa_z1 out  W each point_add operand 1 (accumulator Q)
//  pa_x2..pa_z2 out  W each point_add operand 2 (Q, P or identity)
//  pa_affine    out  1      point_add affine select
//  pa_req_valid out  1      point_add request
//  pa_req_ready in   1      point_add accept
//  pa_req_busy  in   1      point_add busy
//  pa_res_valid in   1      point_add result valid
//  pa_res_ready out  1      point_add result ack (one-cycle pulse)
//  pa_x3..pa_z3 in   W each point_add result
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0 except qy=qz=1 (identity); state IDLE; phase ISSUE.
//  States: IDLE -> ACK -> DBL -> [ADD] -> ... -> NORM -> POST -> IDLE.
//  IDLE: on req_valid, latch scalar/P, Q:=(0,1,0,1), idx:=NBITS-1, req_ready=1, req_busy=1.
//  ACK: req_ready:=0 (exactly one cycle high); -> DBL.
//  Each op (DBL/ADD/NORM) runs two phases:
//   ISSUE: drive operands, pa_affine, pa_req_valid=1 until pa_req_ready seen; then deassert, -> WAIT.
//   WAIT: when pa_res_valid & !pa_req_busy: capture pa_x3..z3, pa_res_ready=1 for one cycle, -> ISSUE of next op.
//  Operands stable from ISSUE entry until WAIT completion.
//  DBL: Q:=Q+Q, affine=0. Then ADD if scalar[idx]=1, else advance bit.
//  ADD: Q:=Q+P, affine=0. Advance bit.
//  Advance bit: idx==0 -> NORM; else idx:=idx-1, -> DBL.
//  NORM: Q:=Q+(0,1,0,1), affine=1; result to qx..qz; res_valid=1, req_busy=0; -> POST.
//  POST: hold q* and res_valid; on res_ready, res_valid:=0 -> IDLE (same-cycle req_valid ignored).
//  scalar=0: all ops still run; NORM yields identity (0,1,0,1).
//  req_valid while busy: ignored; no queueing.
//  Op count (no CT): NBITS + popcount(k) + 1; CT: 2*NBITS + 1.
//  Reset mid-operation: immediate abort, pa_req_valid/pa_res_ready drop, result discarded.
//   point_add shares the system reset and must be reset with this block.
//  q* registers only update at NORM completion; stale values are never flagged valid.
// CONFIGURATION
//  SCALAR_MULT_CT_EN defined: every bit issues DBL then ADD. ADD result written to Q only if
//   scalar[idx]=1, else discarded. Fixed op count and timing independent of k.
//  Undefined: ADD issued only for set bits (data-dependent latency).
// TESTING (bench uses NBITS=4, behavioural point_add model with random 1-20 cycle latency)
//  k=4'b0000 -> q=(0,1,0,1); 5 pa ops (no CT) / 9 (CT); req_ready high exactly 1 cycle.
//  k=4'b0001, P=base point -> q = affine P, qz=1; 6 ops no CT.
//  k=4'b1011 -> q equals golden 11*P; no-CT op sequence D,A,D,D,A,D,A,N.
//  res_ready held low 50 cycles -> q*/res_valid stable; res_ready pulse -> IDLE next cycle.
//  rst_n low during 3rd op WAIT -> outputs at reset values same cycle; next request completes correctly.
//  req_valid asserted during busy and in POST -> no second accept; pa_req_valid never high while pa_res_ready high.

Source files
------------

// File: rtl/scalar_mult_ctrl_if.sv
// scalar_mult_ctrl_if: command/result and point_add bus bundle; slave = controller, master = environment
interface scalar_mult_ctrl_if #(
  parameter int NBITS = 448,
  parameter int W = 448
);
  logic [NBITS-1:0] scalar;
  logic [W-1:0] px, py, pt, pz;
  logic req_valid, req_ready, req_busy;
  logic [W-1:0] qx, qy, qt, qz;
  logic res_valid, res_ready;
  logic [W-1:0] pa_x1, pa_y1, pa_t1, pa_z1;
  logic [W-1:0] pa_x2, pa_y2, pa_t2, pa_z2;
  logic pa_affine, pa_req_valid, pa_req_ready, pa_req_busy, pa_res_valid, pa_res_ready;
  logic [W-1:0] pa_x3, pa_y3, pa_t3, pa_z3;
  modport slave (
    input scalar, px, py, pt, pz, req_valid, res_ready,
    input pa_req_ready, pa_req_busy, pa_res_valid, pa_x3, pa_y3, pa_t3, pa_z3,
    output req_ready, req_busy, qx, qy, qt, qz, res_valid,
    output pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2,
    output pa_affine, pa_req_valid, pa_res_ready
  );
  modport master (
    output scalar, px, py, pt, pz, req_valid, res_ready,
    output pa_req_ready, pa_req_busy, pa_res_valid, pa_x3, pa_y3, pa_t3, pa_z3,
    input req_ready, req_busy, qx, qy, qt, qz, res_valid,
    input pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2,
    input pa_affine, pa_req_valid, pa_res_ready
  );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: MSB-first double-and-add sequencer driving an external point_add, affine-normalised result
//   clk, rst_n (async active-low); bus (slave): scalar/px..pz/req_valid in, req_ready/req_busy out,
//   qx..qz/res_valid out, res_ready in, pa_* operand/handshake to point_add, pa_x3..pa_z3 result in.
//   SCALAR_MULT_CT_EN: issue DBL+ADD for every bit, ADD kept only for set bits (constant timing).
module scalar_mult_ctrl #(
  parameter int NBITS = 448,
  parameter int W = 448
) (
  input logic clk,
  input logic rst_n,
  scalar_mult_ctrl_if.slave bus
);
  localparam int IW = NBITS > 1 ? $clog2(NBITS) : 1;
`ifdef SCALAR_MULT_CT_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ACK, DBL, ADD, NORM, POST} state_t;
  typedef enum logic {ISSUE, WAIT} phase_t;
  state_t state, state_d, adv;
  phase_t phase, phase_d;
  logic [NBITS-1:0] k_r;
  logic [W-1:0] p_x, p_y, p_t, p_z;
  logic [W-1:0] a_x, a_y, a_t, a_z;
  logic [W-1:0] q_x, q_y, q_t, q_z;
  logic [IW-1:0] idx;
  logic op, issue, done, accept, bit_set, wr_acc;
  always_comb begin
    op = state inside {DBL, ADD, NORM};
    issue = op && phase == ISSUE;
    done = op && phase == WAIT && bus.pa_res_valid && !bus.pa_req_busy;
    accept = state == IDLE && bus.req_valid;
    bit_set = k_r[idx];
    adv = idx == '0 ? NORM : DBL;
    phase_d = done ? ISSUE : (issue && bus.pa_req_ready) ? WAIT : phase;
    state_d = state;
    case (state)
      IDLE: state_d = accept ? ACK : IDLE;
      ACK: state_d = DBL;
      DBL: state_d = done ? ((CT || bit_set) ? ADD : adv) : DBL;
      ADD: state_d = done ? adv : ADD;
      NORM: state_d = done ? POST : NORM;
      POST: state_d = bus.res_ready ? IDLE : POST;
      default: state_d = IDLE;
    endcase
    // in CT mode an ADD on a clear bit still runs but its result is dropped
    wr_acc = done && (state == DBL || (state == ADD && bit_set));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= ISSUE;
    end else begin
      state <= state_d;
      phase <= phase_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r <= '0;
      {p_x, p_y, p_t, p_z} <= '0;
      {a_x, a_y, a_t, a_z} <= {W'(0), W'(1), W'(0), W'(1)};
      {q_x, q_y, q_t, q_z} <= {W'(0), W'(1), W'(0), W'(1)};
      idx <= '0;
    end else begin
      if (accept) begin
        k_r <= bus.scalar;
        {p_x, p_y, p_t, p_z} <= {bus.px, bus.py, bus.pt, bus.pz};
        {a_x, a_y, a_t, a_z} <= {W'(0), W'(1), W'(0), W'(1)};
        idx <= IW'(NBITS - 1);
      end
      if (wr_acc) {a_x, a_y, a_t, a_z} <= {bus.pa_x3, bus.pa_y3, bus.pa_t3, bus.pa_z3};
      if (done && state_d == DBL) idx <= idx - IW'(1);
      if (done && state == NORM) {q_x, q_y, q_t, q_z} <= {bus.pa_x3, bus.pa_y3, bus.pa_t3, bus.pa_z3};
    end
  end
  assign bus.req_ready = state == ACK;
  assign bus.req_busy = state inside {ACK, DBL, ADD, NORM};
  assign bus.res_valid = state == POST;
  assign {bus.qx, bus.qy, bus.qt, bus.qz} = {q_x, q_y, q_t, q_z};
  assign bus.pa_req_valid = issue;
  assign bus.pa_res_ready = done;
  assign bus.pa_affine = state == NORM;
  assign bus.pa_x1 = op ? a_x : '0;
  assign bus.pa_y1 = op ? a_y : '0;
  assign bus.pa_t1 = op ? a_t : '0;
  assign bus.pa_z1 = op ? a_z : '0;
  // operand 2: Q for doubling, P for adding, identity (0,1,0,1) for normalising
  assign bus.pa_x2 = state == DBL ? a_x : state == ADD ? p_x : '0;
  assign bus.pa_y2 = state == DBL ? a_y : state == ADD ? p_y : state == NORM ? W'(1) : '0;
  assign bus.pa_t2 = state == DBL ? a_t : state == ADD ? p_t : '0;
  assign bus.pa_z2 = state == DBL ? a_z : state == ADD ? p_z : state == NORM ? W'(1) : '0;
endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb_scalar_mult_ctrl: scoreboard bench with a toy point_add model of random latency
module tb_scalar_mult_ctrl;
  localparam int NBITS = 4;
  localparam int W = 32;
  typedef struct packed {logic [W-1:0] x, y, t, z;} pt_t;
  typedef struct {byte kind; pt_t a; pt_t b; logic aff;} op_t;
  localparam logic [389:0] RST_VEC = {3'b000, 32'd0, 32'd1, 32'd0, 32'd1, 256'd0, 3'b000};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int ops_acc = 0;
  int accepts = 0;
  pt_t resq[$];
  op_t opq[$];
  pt_t p1, p2;
  scalar_mult_ctrl_if #(.NBITS(NBITS), .W(W)) bus ();
  scalar_mult_ctrl #(.NBITS(NBITS), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic pt_t pt_add(input pt_t a, input pt_t b, input logic aff);
    pt_t r;
    r.x = a.x + b.x;
    r.y = W'(1);
    r.t = a.t + b.t;
    r.z = aff ? W'(1) : a.z + b.z;
    return r;
  endfunction
  function automatic logic [389:0] snap();
    return {bus.req_ready, bus.req_busy, bus.res_valid, bus.qx, bus.qy, bus.qt, bus.qz,
            bus.pa_x1, bus.pa_y1, bus.pa_t1, bus.pa_z1, bus.pa_x2, bus.pa_y2, bus.pa_t2, bus.pa_z2,
            bus.pa_affine, bus.pa_req_valid, bus.pa_res_ready};
  endfunction
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // point_add model: accepts when idle, answers after 1-20 cycles, holds result until acked
  logic busy_m, rv_m;
  int cnt_m;
  pt_t r_m;
  assign bus.pa_req_ready = !busy_m && !rv_m;
  assign bus.pa_req_busy = busy_m;
  assign bus.pa_res_valid = rv_m;
  assign {bus.pa_x3, bus.pa_y3, bus.pa_t3, bus.pa_z3} = r_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      rv_m <= 1'b0;
      cnt_m <= 0;
      r_m <= '0;
    end else if (bus.pa_req_valid && !busy_m && !rv_m) begin
      busy_m <= 1'b1;
      cnt_m <= $urandom_range(1, 20);
      r_m <= pt_add({bus.pa_x1, bus.pa_y1, bus.pa_t1, bus.pa_z1},
                    {bus.pa_x2, bus.pa_y2, bus.pa_t2, bus.pa_z2}, bus.pa_affine);
    end else if (busy_m) begin
      if (cnt_m == 1) begin
        busy_m <= 1'b0;
        rv_m <= 1'b1;
      end
      cnt_m <= cnt_m - 1;
    end else if (rv_m && bus.pa_res_ready) rv_m <= 1'b0;
  end
  // operand monitor: each op about to be accepted is popped and compared
  op_t o_mon;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pa_req_valid || bus.pa_res_ready) check("pa_valid_ready_excl", bus.pa_req_valid & bus.pa_res_ready, 0);
      if (bus.req_ready) accepts++;
      if (bus.pa_req_valid && bus.pa_req_ready) begin
        ops_acc++;
        if (opq.size() == 0) check("op_unexpected", 1, 0);
        else begin
          o_mon = opq.pop_front();
          check($sformatf("op%0d_%c", ops_acc, o_mon.kind),
                {bus.pa_x1, bus.pa_y1, bus.pa_t1, bus.pa_z1, bus.pa_x2, bus.pa_y2, bus.pa_t2, bus.pa_z2, bus.pa_affine},
                {o_mon.a, o_mon.b, o_mon.aff});
        end
      end
    end
  end
  // result monitor: compare on each rising res_valid
  logic rv_q = 1'b0;
  pt_t r_exp;
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && !rv_q) begin
      if (resq.size() == 0) check("result_unexpected", 1, 0);
      else begin
        r_exp = resq.pop_front();
        check("result", {bus.qx, bus.qy, bus.qt, bus.qz}, r_exp);
      end
    end
    rv_q = rst_n && bus.res_valid;
  end
  function automatic void push_ops(input logic [NBITS-1:0] k, input pt_t p, input string ops);
    pt_t q, id;
    op_t o;
    string s;
    logic keep;
    id = {W'(0), W'(1), W'(0), W'(1)};
    q = id;
    s = ops;
`ifdef SCALAR_MULT_CT_EN
    s = "";
    for (int i = 0; i < NBITS; i++) s = {s, "DA"};
    s = {s, "N"};
`endif
    for (int i = 0; i < s.len(); i++) begin
      o.kind = s[i];
      o.a = q;
      o.aff = 1'b0;
      keep = 1'b1;
`ifdef SCALAR_MULT_CT_EN
      if (s[i] == "A") keep = k[NBITS-1-i/2];
`else
      if (s[i] == "A") keep = |k;
`endif
      if (s[i] == "D") begin
        o.b = q;
        q = pt_add(q, q, 1'b0);
      end else if (s[i] == "A") begin
        o.b = p;
        if (keep) q = pt_add(q, p, 1'b0);
      end else begin
        o.b = id;
        o.aff = 1'b1;
        q = pt_add(q, id, 1'b1);
      end
      opq.push_back(o);
    end
  endfunction
  task automatic drive_req(input logic [NBITS-1:0] k, input pt_t p);
    bus.scalar = k;
    {bus.px, bus.py, bus.pt, bus.pz} = p;
    bus.req_valid = 1'b1;
  endtask
  task automatic run(input logic [NBITS-1:0] k, input pt_t p, input string ops,
                     input logic [W-1:0] ex, input logic [W-1:0] et, input int hold, input bit spam);
    int n, nops;
    pt_t e;
    e = {ex, W'(1), et, W'(1)};
`ifdef SCALAR_MULT_CT_EN
    nops = 2 * NBITS + 1;
`else
    nops = ops.len();
`endif
    push_ops(k, p, ops);
    resq.push_back(e);
    @(negedge clk);
    ops_acc = 0;
    accepts = 0;
    drive_req(k, p);
    @(negedge clk);
    check($sformatf("k%0h_accept", k), {bus.req_ready, bus.req_busy}, 2'b11);
    if (!spam) bus.req_valid = 1'b0;
    bus.scalar = ~k;
    {bus.px, bus.py, bus.pt, bus.pz} = ~p;
    @(negedge clk);
    check($sformatf("k%0h_ready_pulse", k), {bus.req_ready, bus.req_busy}, 2'b01);
    n = 0;
    while (!bus.res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("k%0h_res_valid", k), bus.res_valid, 1);
    check($sformatf("k%0h_op_count", k), ops_acc, nops);
    check($sformatf("k%0h_ops_left", k), opq.size(), 0);
    repeat (hold) begin
      check($sformatf("k%0h_hold", k), {bus.res_valid, bus.req_busy, bus.qx, bus.qy, bus.qt, bus.qz}, {2'b10, e});
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    check($sformatf("k%0h_idle", k), {bus.res_valid, bus.req_busy, bus.req_ready}, 0);
    @(negedge clk);
    check($sformatf("k%0h_no_reaccept", k), {bus.req_ready, bus.req_busy}, 0);
    check($sformatf("k%0h_accepts", k), accepts, 1);
  endtask
  initial begin
    int n, seen;
    p1 = {32'd7, 32'd5, 32'd3, 32'd9};
    p2 = {32'h1000_0001, 32'h2, 32'h100, 32'h3};
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.scalar = '0;
    {bus.px, bus.py, bus.pt, bus.pz} = '0;
    repeat (3) @(negedge clk);
    check("reset_state", snap(), RST_VEC);
    rst_n = 1'b1;
    run(4'b0000, p1, "DDDDN", 32'd0, 32'd0, 2, 1'b0);
    run(4'b0001, p1, "DDDDAN", 32'd7, 32'd3, 50, 1'b0);
    run(4'b1011, p1, "DADDADAN", 32'd77, 32'd33, 2, 1'b1);
    run(4'b1000, p1, "DADDDN", 32'd56, 32'd24, 2, 1'b0);
    run(4'b1111, p2, "DADADADAN", 32'hF000_000F, 32'h0000_0F00, 2, 1'b0);
    push_ops(4'b1011, p1, "DADDADAN");
    @(negedge clk);
    drive_req(4'b1011, p1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    seen = 0;
    while (seen < 3 && n < 1000) begin
      if (bus.pa_req_valid && bus.pa_req_ready) seen++;
      if (seen < 3) @(negedge clk);
      n++;
    end
    check("reach_op3", seen, 3);
    @(negedge clk);
    check("op3_wait", {bus.pa_req_valid, bus.pa_res_ready, bus.req_busy}, 3'b001);
    rst_n = 1'b0;
    #1;
    check("abort_state", snap(), RST_VEC);
    opq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(4'b1011, p2, "DADDADAN", 32'hB000_000B, 32'h0000_0B00, 2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
